// File: rtl/s3_writeback_pkg.sv
// Shared encodings for the stage-3 writeback block: opcodes, load widths,
// CSR addresses and the writeback-select code used by s3_control.
package s3_writeback_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h4000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // inst[6:2] of the major opcodes
    localparam logic [4:0] OPC_LOAD_5   = 5'b00000;
    localparam logic [4:0] OPC_ARI_I_5  = 5'b00100;
    localparam logic [4:0] OPC_STORE_5  = 5'b01000;
    localparam logic [4:0] OPC_ARI_R_5  = 5'b01100;
    localparam logic [4:0] OPC_LUI_5    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
    localparam logic [4:0] OPC_JALR_5   = 5'b11001;
    localparam logic [4:0] OPC_JAL_5    = 5'b11011;
    localparam logic [4:0] OPC_CSR_5    = 5'b11100;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;

    localparam logic [2:0] FNC_CSRRW  = 3'b001;
    localparam logic [2:0] FNC_CSRRWI = 3'b101;

    localparam logic [11:0] CSR_TOHOST  = 12'h51E;
    localparam logic [11:0] CSR_CYCLE   = 12'hC00;
    localparam logic [11:0] CSR_INSTRET = 12'hC02;

    typedef enum logic [1:0] {
        WB_SEL_LOAD = 2'd0,
        WB_SEL_ALU  = 2'd1,
        WB_SEL_PC4  = 2'd2,
        WB_SEL_CSR  = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/s3_writeback_if.sv
// s2->s3 pipeline bus plus the register-file writeback port.
interface s3_writeback_if;
    logic        valid_s2;
    logic [31:0] inst_s2;
    logic [31:0] pc_s2;
    logic [31:0] alu_s2;
    logic [31:0] rs1_s2;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_we;

    // stage 2 side: produces the pipeline results, consumes writeback for forwarding
    modport master (
        output valid_s2, inst_s2, pc_s2, alu_s2, rs1_s2,
        input  wb_addr, wb_data, wb_we
    );

    // stage 3 side
    modport slave (
        input  valid_s2, inst_s2, pc_s2, alu_s2, rs1_s2,
        output wb_addr, wb_data, wb_we
    );
endinterface

// File: rtl/s3_load_align.sv
// Byte-lane alignment and sign/zero extension of a DMEM read word.
module s3_load_align
    import s3_writeback_pkg::*;
(
    input  logic [31:0] dmem_dout,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [15:0] half;

    // Shift right by whole bytes; zero fill makes a halfword at off=3 pick up 0 as its upper byte.
    assign half = 16'(dmem_dout >> {off, 3'b000});

    // Select width and extension from funct3; word loads ignore the offset.
    always_comb begin
        load_data = dmem_dout;
        case (funct3)
            FNC_LB:  load_data = 32'($signed(half[7:0]));
            FNC_LBU: load_data = {24'b0, half[7:0]};
            FNC_LH:  load_data = 32'($signed(half));
            FNC_LHU: load_data = {16'b0, half};
            default: load_data = dmem_dout;
        endcase
    end

endmodule

// File: rtl/s3_writeback.sv
// Stage 3 of the RV32I core: s2/s3 pipeline register, load alignment,
// CSR file (tohost, cycle, instret) and the register writeback mux.
module s3_writeback
    import s3_writeback_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    s3_writeback_if.slave bus,
    input  logic [31:0]   dmem_dout,
    input  logic [1:0]    wb_sel,
    input  logic          reg_we,
    output logic [31:0]   inst_s3,
    output logic [31:0]   pc_s3,
    output logic [31:0]   csr_tohost
);

    logic [31:0] alu_s3;
    logic [31:0] rs1_s3;
    logic        valid_s3;
    logic [31:0] cycle;
    logic [31:0] instret;

    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic        csr_active;
    logic [31:0] csr_rdata;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic [31:0] load_data;

    // Pipeline register: flush injects a bubble even when stalled, stall holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_s3  <= NOP_INST;
            pc_s3    <= PC_RESET;
            alu_s3   <= '0;
            rs1_s3   <= '0;
            valid_s3 <= 1'b0;
        end else if (flush) begin
            inst_s3  <= NOP_INST;
            pc_s3    <= PC_RESET;
            alu_s3   <= '0;
            rs1_s3   <= '0;
            valid_s3 <= 1'b0;
        end else if (!stall) begin
            inst_s3  <= bus.inst_s2;
            pc_s3    <= bus.pc_s2;
            alu_s3   <= bus.alu_s2;
            rs1_s3   <= bus.rs1_s2;
            valid_s3 <= bus.valid_s2;
        end
    end

    // Free-running cycle counter; keeps counting through stall and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle <= '0;
        else     cycle <= cycle + 32'd1;
    end

    // Retired-instruction counter; an instruction leaving s3 counts even if s3 is flushed behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       instret <= '0;
        else if (valid_s3 && !stall)   instret <= instret + 32'd1;
    end

    // tohost write commits only when the instruction actually leaves s3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          csr_tohost <= '0;
        else if (csr_wen) csr_tohost <= csr_wdata;
    end

    assign funct3     = inst_s3[14:12];
    assign csr_addr   = inst_s3[31:20];
    assign csr_active = valid_s3 && (inst_s3[6:2] == OPC_CSR_5);

    // CSR read port and write-data/enable decode; reads see the pre-write value.
    always_comb begin
        csr_rdata = '0;
        csr_wdata = '0;
        csr_wen   = 1'b0;
        if (csr_active) begin
            case (csr_addr)
                CSR_TOHOST:  csr_rdata = csr_tohost;
                CSR_CYCLE:   csr_rdata = cycle;
                CSR_INSTRET: csr_rdata = instret;
                default:     csr_rdata = '0;
            endcase
            case (funct3)
                FNC_CSRRW:  begin csr_wdata = rs1_s3;                   csr_wen = 1'b1; end
                FNC_CSRRWI: begin csr_wdata = {27'b0, inst_s3[19:15]};  csr_wen = 1'b1; end
                default:    begin csr_wdata = '0;                       csr_wen = 1'b0; end
            endcase
            csr_wen = csr_wen && (csr_addr == CSR_TOHOST) && !stall && !flush;
        end
    end

    s3_load_align u_load_align (
        .dmem_dout (dmem_dout),
        .off       (alu_s3[1:0]),
        .funct3    (funct3),
        .load_data (load_data)
    );

    // Writeback value select.
    always_comb begin
        bus.wb_data = alu_s3;
        case (wb_sel_e'(wb_sel))
            WB_SEL_LOAD: bus.wb_data = load_data;
            WB_SEL_ALU:  bus.wb_data = alu_s3;
            WB_SEL_PC4:  bus.wb_data = pc_s3 + 32'd4;
            WB_SEL_CSR:  bus.wb_data = csr_rdata;
            default:     bus.wb_data = alu_s3;
        endcase
    end

    assign bus.wb_addr = inst_s3[11:7];
    assign bus.wb_we   = reg_we && valid_s3 && (inst_s3[11:7] != 5'd0);

endmodule

// File: tb/tb_s3_writeback.sv
// Bench for s3_writeback: random and directed stimulus, reference model,
// scoreboard queue drained by an independent monitor on the falling edge.
module tb_s3_writeback;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] PCR = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [31:0] dmem_dout;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic [31:0] inst_s3, pc_s3, csr_tohost;

    s3_writeback_if bus ();

    s3_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .bus        (bus),
        .dmem_dout  (dmem_dout),
        .wb_sel     (wb_sel),
        .reg_we     (reg_we),
        .inst_s3    (inst_s3),
        .pc_s3      (pc_s3),
        .csr_tohost (csr_tohost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] wbd;
        logic [31:0] tohost;
        logic [4:0]  addr;
        logic        we;
    } exp_t;

    exp_t sbq[$];
    int n_checks = 0;
    int n_fail   = 0;

    // reference state of the s3 stage
    logic [31:0] m_inst, m_pc, m_alu, m_rs1, m_tohost, m_cycle, m_instret;
    logic        m_valid;
    // inputs applied for the coming edge
    logic        d_st, d_fl, d_v;
    logic [31:0] d_inst, d_pc, d_alu, d_rs1;

    logic [2:0]  ld_f3  [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  csr_f3 [4] = '{3'd1, 3'd5, 3'd2, 3'd6};
    logic [11:0] csr_ad [3] = '{12'h51E, 12'hC00, 12'hC02};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_i(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1f,
                                         input logic [11:0] imm);
        return {imm, rs1f, f3, rd, opc};
    endfunction

    // what s3_control would answer for an instruction
    function automatic logic [1:0] ctl_sel(input logic [31:0] i);
        case (i[6:0])
            7'h03:        return 2'd0;
            7'h6F, 7'h67: return 2'd2;
            7'h73:        return 2'd3;
            default:      return 2'd1;
        endcase
    endfunction

    function automatic logic ctl_we(input logic [31:0] i);
        return !(i[6:0] == 7'h23 || i[6:0] == 7'h63);
    endfunction

    // load result from byte arithmetic on the addressed lanes
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] sh, v;
        sh = w / (32'd1 << (8 * off));
        case (f3)
            3'd0: begin v = sh % 256;   if (v >= 128)   v = v - 32'd256;   end
            3'd4: v = sh % 256;
            3'd1: begin v = sh % 65536; if (v >= 32768) v = v - 32'd65536; end
            3'd5: v = sh % 65536;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_csr();
        if (!(m_valid && m_inst[6:0] == 7'h73)) return 32'd0;
        if (m_inst[31:20] == 12'h51E) return m_tohost;
        if (m_inst[31:20] == 12'hC00) return m_cycle;
        if (m_inst[31:20] == 12'hC02) return m_instret;
        return 32'd0;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 6)
            0: return mk_i(7'h03, ld_f3[$urandom % 5], r[11:7], r[19:15], r[31:20]);
            1: return {r[31:7], 7'h13};
            2: return {r[31:7], 7'h6F};
            3: return mk_i(7'h73, csr_f3[$urandom % 4], r[11:7], r[19:15],
                           ($urandom % 4 == 3) ? r[31:20] : csr_ad[$urandom % 3]);
            4: return {r[31:7], 7'h23};
            default: return {r[31:7], 7'h37};
        endcase
    endfunction

    task automatic model_reset();
        m_inst = NOP; m_pc = PCR; m_alu = 0; m_rs1 = 0; m_valid = 0;
        m_tohost = 0; m_cycle = 0; m_instret = 0;
    endtask

    task automatic model_edge();
        if (m_valid && m_inst[6:0] == 7'h73 && !d_st && !d_fl && m_inst[31:20] == 12'h51E) begin
            if (m_inst[14:12] == 3'd1)      m_tohost = m_rs1;
            else if (m_inst[14:12] == 3'd5) m_tohost = 32'(m_inst[19:15]);
        end
        if (m_valid && !d_st) m_instret = m_instret + 1;
        m_cycle = m_cycle + 1;
        if (d_fl) begin
            m_inst = NOP; m_pc = PCR; m_alu = 0; m_rs1 = 0; m_valid = 0;
        end else if (!d_st) begin
            m_inst = d_inst; m_pc = d_pc; m_alu = d_alu; m_rs1 = d_rs1; m_valid = d_v;
        end
    endtask

    // apply inputs for the current s3 cycle and queue what the outputs must be
    task automatic drive(input logic st, input logic fl, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs1,
                         input logic [31:0] dout);
        exp_t e;
        d_st = st; d_fl = fl; d_v = v; d_inst = inst; d_pc = pc; d_alu = alu; d_rs1 = rs1;
        stall = st; flush = fl; dmem_dout = dout;
        bus.valid_s2 = v; bus.inst_s2 = inst; bus.pc_s2 = pc; bus.alu_s2 = alu; bus.rs1_s2 = rs1;
        wb_sel = ctl_sel(m_inst);
        reg_we = ctl_we(m_inst);
        e.inst = m_inst; e.pc = m_pc; e.tohost = m_tohost; e.addr = m_inst[11:7];
        e.we = reg_we && m_valid && (m_inst[11:7] != 0);
        case (wb_sel)
            2'd0:    e.wbd = ref_load(dout, m_alu[1:0], m_inst[14:12]);
            2'd1:    e.wbd = m_alu;
            2'd2:    e.wbd = m_pc + 4;
            default: e.wbd = ref_csr();
        endcase
        sbq.push_back(e);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // monitor: compare the DUT's outputs against each queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("inst_s3", inst_s3, e.inst);
                chk("pc_s3", pc_s3, e.pc);
                chk("wb_data", bus.wb_data, e.wbd);
                chk("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
                chk("wb_we", 32'(bus.wb_we), 32'(e.we));
                chk("csr_tohost", csr_tohost, e.tohost);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c0, i0, lbi, yi, r;
        rst = 1'b1; stall = 0; flush = 0; dmem_dout = 0; wb_sel = 2'd1; reg_we = 1'b1;
        bus.valid_s2 = 0; bus.inst_s2 = NOP; bus.pc_s2 = 0; bus.alu_s2 = 0; bus.rs1_s2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst", inst_s3, NOP);
        chk("rst_pc", pc_s3, PCR);
        chk("rst_wb_we", 32'(bus.wb_we), 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_tohost", csr_tohost, 0);
        rst = 1'b0;

        // load alignment
        lbi = mk_i(7'h03, 3'd0, 5'd5, 5'd1, 12'd0);
        drive(0, 0, 1, lbi, PCR, 32'h1003, 0, 0); advance();
        drive(0, 0, 1, mk_i(7'h03, 3'd4, 5'd5, 5'd1, 12'd0), PCR + 4, 32'h1003, 0, 32'h80FF_0000);
        #1 chk("lb_off3", bus.wb_data, 32'hFFFF_FF80); advance();
        drive(0, 0, 1, mk_i(7'h03, 3'd1, 5'd5, 5'd1, 12'd0), PCR + 8, 32'h1002, 0, 32'h80FF_0000);
        #1 chk("lbu_off3", bus.wb_data, 32'h0000_0080); advance();
        drive(0, 0, 1, mk_i(7'h03, 3'd5, 5'd5, 5'd1, 12'd0), PCR + 12, 32'h1002, 0, 32'h80FF_0000);
        #1 chk("lh_off2", bus.wb_data, 32'hFFFF_80FF); advance();
        drive(0, 0, 1, NOP, PCR + 16, 0, 0, 32'h80FF_0000);
        #1 chk("lhu_off2", bus.wb_data, 32'h0000_80FF); advance();

        // jal link value and x0 suppression
        drive(0, 0, 1, 32'h0000_00EF, 32'h4000_0010, 0, 0, 0); advance();
        drive(0, 0, 1, 32'h0000_006F, 32'h4000_0010, 0, 0, 0);
        #1 chk("jal_wb_data", bus.wb_data, 32'h4000_0014);
        chk("jal_wb_addr", 32'(bus.wb_addr), 1);
        chk("jal_wb_we", 32'(bus.wb_we), 1); advance();
        drive(0, 0, 1, NOP, PCR, 0, 0, 0);
        #1 chk("jal_x0_wb_we", 32'(bus.wb_we), 0); advance();

        // tohost writes
        drive(0, 0, 1, mk_i(7'h73, 3'd5, 5'd0, 5'd5, 12'h51E), PCR, 0, 0, 0); advance();
        drive(0, 0, 1, NOP, PCR, 0, 0, 0); advance();
        chk("csrrwi_tohost", csr_tohost, 5);
        drive(0, 0, 1, mk_i(7'h73, 3'd5, 5'd3, 5'd9, 12'h51E), PCR, 0, 0, 0); advance();
        drive(1, 0, 1, NOP, PCR, 0, 0, 0); advance();
        chk("stalled_tohost", csr_tohost, 5);
        drive(0, 0, 1, NOP, PCR, 0, 0, 0); advance();
        chk("unstalled_tohost", csr_tohost, 9);
        drive(0, 0, 1, mk_i(7'h73, 3'd1, 5'd4, 5'd2, 12'h51E), PCR, 0, 32'h0000_DEAD, 0); advance();
        drive(0, 0, 1, NOP, PCR, 0, 0, 0); advance();
        chk("csrrw_tohost", csr_tohost, 32'h0000_DEAD);

        // stall+flush, then a three-cycle stall
        drive(0, 0, 1, 32'h0010_0093, 32'h4000_0100, 7, 0, 0); advance();
        drive(1, 1, 1, 32'h0020_0113, 32'h4000_0104, 8, 0, 0); advance();
        chk("flush_inst", inst_s3, NOP);
        chk("flush_valid", 32'(dut.valid_s3), 0);
        yi = 32'h0030_0193;
        drive(0, 0, 1, yi, 32'h4000_0200, 9, 0, 0); advance();
        c0 = m_cycle; i0 = m_instret;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 32'h0040_0213, 32'h4000_0204, 10, 0, 0); advance();
        end
        chk("stall_inst", inst_s3, yi);
        chk("stall_cycle", dut.cycle, c0 + 3);
        chk("stall_instret", dut.instret, i0);

        // cycle wrap and CSR read of cycle
        drive(0, 0, 1, mk_i(7'h73, 3'd2, 5'd6, 5'd0, 12'hC00), PCR, 0, 0, 0); advance();
        force dut.cycle = 32'hFFFF_FFFF;
        #1 release dut.cycle;
        m_cycle = 32'hFFFF_FFFF;
        drive(0, 0, 1, NOP, PCR, 0, 0, 0);
        #1 chk("csr_cycle_read", bus.wb_data, 32'hFFFF_FFFF); advance();
        chk("cycle_wrap", dut.cycle, 0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            drive(($urandom % 5) == 0, ($urandom % 10) == 0, ($urandom % 4) != 0, rand_inst(),
                  {r[31:2], 2'b00}, $urandom, $urandom, $urandom);
            advance();
        end

        // asynchronous reset mid-cycle with non-zero state
        drive(0, 0, 1, mk_i(7'h73, 3'd5, 5'd0, 5'd7, 12'h51E), PCR, 0, 0, 0); advance();
        drive(0, 0, 1, 32'h0050_0293, 32'h4000_0300, 3, 0, 0); advance();
        @(negedge clk);
        wb_sel = 2'd1; reg_we = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_inst", inst_s3, NOP);
        chk("arst_pc", pc_s3, PCR);
        chk("arst_wb_we", 32'(bus.wb_we), 0);
        chk("arst_wb_data", bus.wb_data, 0);
        chk("arst_tohost", csr_tohost, 0);
        chk("arst_cycle", dut.cycle, 0);
        chk("arst_instret", dut.instret, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            r = $urandom;
            drive(($urandom % 5) == 0, ($urandom % 10) == 0, 1'b1, rand_inst(),
                  {r[31:2], 2'b00}, $urandom, $urandom, $urandom);
            advance();
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
